ysyx_25040129_csr_ctrl: RTL and testbench

Sequencing initiator for the CSR register file. Accepts one CSR/trap micro-operation at a time from the execute stage and drives the register file's single combinational-read/registered-write port. Performs read-modify-write for CSRRW/CSRRS/CSRRC. Performs the multi-cycle ECALL entry (MEPC, MCAUSE, MTVEC) and MRET return, and produces the redirect PC for the fetch stage.

---
 rtl/ysyx_25040129_csr_pkg.sv | 32 +++
 rtl/ysyx_25040129_csr_alu.sv | 21 ++
 rtl/ysyx_25040129_csr_ctrl.sv | 157 +++++++++++++++
 tb/tb_ysyx_25040129_csr_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_csr_pkg.sv
// Shared definitions for the CSR sequencing controller and the CSR register file.
package ysyx_25040129_csr_pkg;

  localparam int unsigned CSR_AW       = 12;
  localparam logic [31:0] MCAUSE_ECALL = 32'd11;

  localparam logic [CSR_AW-1:0] MSTATUS   = 12'h300;
  localparam logic [CSR_AW-1:0] MTVEC     = 12'h305;
  localparam logic [CSR_AW-1:0] MEPC      = 12'h341;
  localparam logic [CSR_AW-1:0] MCAUSE    = 12'h342;
  localparam logic [CSR_AW-1:0] MVENDORID = 12'hF11;
  localparam logic [CSR_AW-1:0] MARCHID   = 12'hF12;

  typedef enum logic [2:0] {
    CSRRW = 3'd0,
    CSRRS = 3'd1,
    CSRRC = 3'd2,
    ECALL = 3'd3,
    MRET  = 3'd4
  } csr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RMW   = 3'd1,
    ST_EPC   = 3'd2,
    ST_CAUSE = 3'd3,
    ST_VEC   = 3'd4,
    ST_RET   = 3'd5,
    ST_RESP  = 3'd6
  } csr_state_t;

endpackage

// File: rtl/ysyx_25040129_csr_alu.sv
// Write-data merge for CSR read-modify-write: replace, set bits, or clear bits.
module ysyx_25040129_csr_alu
  import ysyx_25040129_csr_pkg::*;
(
  input  csr_op_t     op,
  input  logic [31:0] old_val,
  input  logic [31:0] src,
  output logic [31:0] data
);

  // Merge the old CSR value with the source operand according to the op.
  always_comb begin
    data = src;
    case (op)
      CSRRS:   data = old_val | src;
      CSRRC:   data = old_val & ~src;
      default: data = src;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_csr_ctrl.sv
// Sequences one CSR or trap micro-op at a time onto the CSR register file port
// and returns the old CSR value plus an optional fetch redirect.
module ysyx_25040129_csr_ctrl
  import ysyx_25040129_csr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [CSR_AW-1:0] req_addr,
  input  logic [31:0]       req_src,
  input  logic              req_wen,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rd,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CSR_AW-1:0] csr_read_addr,
  input  logic [31:0]       csr_out,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [31:0]       csr_data
);

  csr_state_t        state, state_nxt;
  csr_op_t           op_p0;
  logic [CSR_AW-1:0] addr_p0;
  logic [31:0]       src_p0;
  logic              wen_p0;
  logic [31:0]       pc_p0;
  logic [31:0]       rd_p1;
  logic [31:0]       rpc_p1;
  logic              redir_p1;
  logic [31:0]       alu_data;
  logic              accept;

  assign accept         = req_valid && req_ready;
  assign req_ready      = (state == ST_IDLE);
  assign resp_valid     = (state == ST_RESP);
  assign redirect_valid = resp_valid && redir_p1;
  assign resp_rd        = rd_p1;
  assign redirect_pc    = rpc_p1;

  ysyx_25040129_csr_alu u_alu (
    .op      (op_p0),
    .old_val (csr_out),
    .src     (src_p0),
    .data    (alu_data)
  );

  // Next-state selection; the op dispatch happens only on acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (csr_op_t'(req_op))
            CSRRW, CSRRS, CSRRC: state_nxt = ST_RMW;
            ECALL:               state_nxt = ST_EPC;
            MRET:                state_nxt = ST_RET;
            default:             state_nxt = ST_RESP;
          endcase
        end
      end
      ST_RMW:   state_nxt = ST_RESP;
      ST_EPC:   state_nxt = ST_CAUSE;
      ST_CAUSE: state_nxt = ST_VEC;
      ST_VEC:   state_nxt = ST_RESP;
      ST_RET:   state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Register-file port decode; everything except csr_data in RMW follows state and latched fields.
  always_comb begin
    csr_read_addr  = '0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_data       = '0;
    case (state)
      ST_RMW: begin
        csr_read_addr  = addr_p0;
        csr_write      = (op_p0 == CSRRW) || wen_p0;
        csr_write_addr = addr_p0;
        csr_data       = alu_data;
      end
      ST_EPC: begin
        csr_write      = 1'b1;
        csr_write_addr = MEPC;
        csr_data       = pc_p0;
      end
      ST_CAUSE: begin
        csr_write      = 1'b1;
        csr_write_addr = MCAUSE;
        csr_data       = MCAUSE_ECALL;
      end
      ST_VEC:  csr_read_addr = MTVEC;
      ST_RET:  csr_read_addr = MEPC;
      default: ;
    endcase
  end

  // State register; an asynchronous reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Stage 0: latch the accepted request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p0   <= CSRRW;
      addr_p0 <= '0;
      src_p0  <= '0;
      wen_p0  <= 1'b0;
      pc_p0   <= '0;
    end else if (accept) begin
      op_p0   <= csr_op_t'(req_op);
      addr_p0 <= req_addr;
      src_p0  <= req_src;
      wen_p0  <= req_wen;
      pc_p0   <= req_pc;
    end
  end

  // Stage 1: capture old CSR value and redirect target; held stable through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_p1    <= '0;
      rpc_p1   <= '0;
      redir_p1 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_p1    <= '0;
            redir_p1 <= 1'b0;
          end
        end
        ST_RMW: rd_p1 <= csr_out;
        ST_VEC: begin
          rpc_p1   <= {csr_out[31:2], 2'b00};
          redir_p1 <= 1'b1;
        end
        ST_RET: begin
          rpc_p1   <= csr_out;
          redir_p1 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_csr_ctrl.sv
// Directed bench for the CSR sequencing controller with a behavioural CSR register file.
module tb_ysyx_25040129_csr_ctrl;
  import ysyx_25040129_csr_pkg::*;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [CSR_AW-1:0] req_addr;
  logic [31:0]       req_src;
  logic              req_wen;
  logic [31:0]       req_pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rd;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [CSR_AW-1:0] csr_read_addr;
  logic [31:0]       csr_out;
  logic              csr_write;
  logic [CSR_AW-1:0] csr_write_addr;
  logic [31:0]       csr_data;

  logic [31:0]       rf [0:4095];
  logic [CSR_AW-1:0] wa [0:3];
  logic [31:0]       wd [0:3];

  int n_checks;
  int n_fail;

  typedef struct {
    logic [2:0]        op;
    logic [CSR_AW-1:0] addr;
    logic [31:0]       src;
    logic              wen;
    logic [31:0]       pc;
    logic [31:0]       rd;
    logic              rv;
    logic [31:0]       rpc;
    int                lat;
    int                nwr;
  } vec_t;

  vec_t vecs [12];

  ysyx_25040129_csr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_src        (req_src),
    .req_wen        (req_wen),
    .req_pc         (req_pc),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rd        (resp_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_read_addr  (csr_read_addr),
    .csr_out        (csr_out),
    .csr_write      (csr_write),
    .csr_write_addr (csr_write_addr),
    .csr_data       (csr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write commits on the clock edge.
  assign csr_out = rf[csr_read_addr];
  always @(posedge clk) begin
    if (csr_write) rf[csr_write_addr] <= csr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},      {31'd0, req_ready},      32'd1);
    check({tag, " resp_valid"},     {31'd0, resp_valid},     32'd0);
    check({tag, " redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, " csr_write"},      {31'd0, csr_write},      32'd0);
    check({tag, " resp_rd"},        resp_rd,                 32'd0);
    check({tag, " redirect_pc"},    redirect_pc,             32'd0);
    check({tag, " csr_read_addr"},  {20'd0, csr_read_addr},  32'd0);
    check({tag, " csr_write_addr"}, {20'd0, csr_write_addr}, 32'd0);
    check({tag, " csr_data"},       csr_data,                32'd0);
  endtask

  // Offer one op, wait (bounded) for the response, and log writes seen on the way.
  task automatic run_op(input logic [2:0] op, input logic [CSR_AW-1:0] addr,
                        input logic [31:0] src, input logic wen, input logic [31:0] pc,
                        output int lat, output int nwr);
    @(negedge clk);
    req_op = op; req_addr = addr; req_src = src; req_wen = wen; req_pc = pc;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    nwr = 0;
    while (!resp_valid && lat < 20) begin
      if (csr_write) begin
        if (nwr < 4) begin
          wa[nwr] = csr_write_addr;
          wd[nwr] = csr_data;
        end
        nwr++;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nwr;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) rf[i] = 32'd0;
    rst = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_src = '0;
    req_wen = 1'b0; req_pc = '0; resp_ready = 1'b1;

    //              op     addr     src            wen   pc             rd             rv    rpc            lat nwr
    vecs[0]  = '{CSRRW, MTVEC,   32'h8000_0100, 1'b1, 32'h0,         32'h0,         1'b0, 32'h0,         2, 1};
    vecs[1]  = '{CSRRS, MTVEC,   32'h0,         1'b0, 32'h0,         32'h8000_0100, 1'b0, 32'h0,         2, 0};
    vecs[2]  = '{CSRRW, MSTATUS, 32'h1800,      1'b1, 32'h0,         32'h0,         1'b0, 32'h0,         2, 1};
    vecs[3]  = '{CSRRC, MSTATUS, 32'h0800,      1'b1, 32'h0,         32'h1800,      1'b0, 32'h0,         2, 1};
    vecs[4]  = '{CSRRS, MSTATUS, 32'h0008,      1'b1, 32'h0,         32'h1000,      1'b0, 32'h0,         2, 1};
    vecs[5]  = '{CSRRW, MTVEC,   32'h8000_0103, 1'b1, 32'h0,         32'h8000_0100, 1'b0, 32'h0,         2, 1};
    vecs[6]  = '{ECALL, 12'h0,   32'h0,         1'b0, 32'h8000_0040, 32'h0,         1'b1, 32'h8000_0100, 4, 2};
    vecs[7]  = '{MRET,  12'h0,   32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 32'h8000_0040, 2, 0};
    vecs[8]  = '{3'd7,  MSTATUS, 32'hFFFF,      1'b1, 32'h0,         32'h0,         1'b0, 32'h0,         1, 0};
    vecs[9]  = '{3'd5,  MTVEC,   32'h1234,      1'b1, 32'h0,         32'h0,         1'b0, 32'h0,         1, 0};
    vecs[10] = '{CSRRC, MSTATUS, 32'h0,         1'b0, 32'h0,         32'h1008,      1'b0, 32'h0,         2, 0};
    vecs[11] = '{CSRRS, MCAUSE,  32'h0,         1'b0, 32'h0,         32'd11,        1'b0, 32'h0,         2, 0};

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].wen, vecs[i].pc, lat, nwr);
      check($sformatf("v%0d latency", i),  lat,                     vecs[i].lat);
      check($sformatf("v%0d resp_rd", i),  resp_rd,                 vecs[i].rd);
      check($sformatf("v%0d redir_v", i),  {31'd0, redirect_valid}, {31'd0, vecs[i].rv});
      check($sformatf("v%0d writes", i),   nwr,                     vecs[i].nwr);
      if (vecs[i].rv) check($sformatf("v%0d redir_pc", i), redirect_pc, vecs[i].rpc);
      if (vecs[i].op == ECALL) begin
        check("ecall w0 addr", {20'd0, wa[0]}, {20'd0, MEPC});
        check("ecall w0 data", wd[0],          vecs[i].pc);
        check("ecall w1 addr", {20'd0, wa[1]}, {20'd0, MCAUSE});
        check("ecall w1 data", wd[1],          32'd11);
      end
    end
    check("rf MSTATUS", rf[MSTATUS], 32'h1008);
    check("rf MTVEC",   rf[MTVEC],   32'h8000_0103);
    check("rf MEPC",    rf[MEPC],    32'h8000_0040);
    check("rf MCAUSE",  rf[MCAUSE],  32'd11);

    // Response back-pressure: MRET response held while a new request is offered.
    @(negedge clk);
    req_op = MRET; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("stall latency", lat, 2);
    req_op = CSRRW; req_addr = MSTATUS; req_src = 32'hDEAD; req_wen = 1'b1; req_valid = 1'b1;
    nwr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall resp_valid", {31'd0, resp_valid},     32'd1);
      check("stall resp_rd",    resp_rd,                 32'd0);
      check("stall redir_v",    {31'd0, redirect_valid}, 32'd1);
      check("stall redir_pc",   redirect_pc,             32'h8000_0040);
      check("stall req_ready",  {31'd0, req_ready},      32'd0);
      if (csr_write) nwr++;
    end
    check("stall writes", nwr, 0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("after hs req_ready",  {31'd0, req_ready},  32'd1);
    check("after hs resp_valid", {31'd0, resp_valid}, 32'd0);
    check("stall rf MSTATUS",    rf[MSTATUS],         32'h1008);

    // Reset asserted during CAUSE: write drops at once, EPC write already committed.
    run_op(CSRRW, MCAUSE, 32'h0, 1'b1, 32'h0, lat, nwr);
    check("clear mcause rd", resp_rd, 32'd11);
    @(negedge clk);
    req_op = ECALL; req_pc = 32'h8000_0080; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("epc write",      {31'd0, csr_write},      32'd1);
    check("epc write addr", {20'd0, csr_write_addr}, {20'd0, MEPC});
    @(negedge clk);
    check("cause write",      {31'd0, csr_write},      32'd1);
    check("cause write addr", {20'd0, csr_write_addr}, {20'd0, MCAUSE});
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check("midreset rf MEPC",   rf[MEPC],   32'h8000_0080);
    check("midreset rf MCAUSE", rf[MCAUSE], 32'd0);
    rst = 1'b1;

    run_op(ECALL, 12'h0, 32'h0, 1'b0, 32'h8000_0080, lat, nwr);
    check("re-ecall latency",  lat,                     4);
    check("re-ecall writes",   nwr,                     2);
    check("re-ecall resp_rd",  resp_rd,                 32'd0);
    check("re-ecall redir_v",  {31'd0, redirect_valid}, 32'd1);
    check("re-ecall redir_pc", redirect_pc,             32'h8000_0100);
    @(negedge clk);
    check("re-ecall rf MCAUSE", rf[MCAUSE], 32'd11);

    run_op(3'd7, MSTATUS, 32'hFFFF_FFFF, 1'b1, 32'h0, lat, nwr);
    check("illegal latency", lat,                     1);
    check("illegal writes",  nwr,                     0);
    check("illegal resp_rd", resp_rd,                 32'd0);
    check("illegal redir_v", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    check("illegal rf MSTATUS", rf[MSTATUS], 32'h1008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
